// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit: multi-cycle RV32M multiply/divide responder for the execute
// stage. It holds the pipe via freeze_pipe and presents C / C_hi with a
// one-cycle valid pulse. The divider is radix-2 restoring and produces one
// quotient bit per cycle.
// Build option: define MULDIV_ITER_MUL_EN to replace the single-cycle multiplier
// with a shift-add multiplier that takes XLEN cycles.
module riscv_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            div_en,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            freeze_pipe,
  output logic            valid,
  output logic [XLEN-1:0] C,
  output logic [XLEN-1:0] C_hi
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;        // operand magnitudes
  logic [XLEN-1:0]   rem_q, rem_d, quo_q, quo_d; // iteration working registers
  logic [XLEN-1:0]   c_q, c_d, c_hi_q, c_hi_d;
  logic              a_neg_q, a_neg_d, neg_q, neg_d, dz_q, dz_d, ov_q, ov_d;

  logic              accept_s, last_s, a_neg_s, b_neg_s, dz_s, ov_s, ge_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s, a_orig_s;
  logic [XLEN:0]     shifted_s, diff_s;
  logic [XLEN-1:0]   div_rem_n_s, div_quo_n_s, q_s, r_s, res_lo_s, res_hi_s;
  logic [2*XLEN-1:0] prod_mag_s, prod_s;
`ifdef MULDIV_ITER_MUL_EN
  logic [XLEN:0]     mac_s;
  logic [XLEN-1:0]   mul_hi_n_s, mul_lo_n_s;
`endif

  // rs1 is treated as signed for MUL, MULH, MULHSU, DIV, REM
  function automatic logic a_signed_f(input logic [2:0] f);
    case (f)
      3'd0, 3'd1, 3'd2, 3'd4, 3'd6: a_signed_f = 1'b1;
      default:                      a_signed_f = 1'b0;
    endcase
  endfunction

  // rs2 is treated as signed for MUL, MULH, DIV, REM
  function automatic logic b_signed_f(input logic [2:0] f);
    case (f)
      3'd0, 3'd1, 3'd4, 3'd6: b_signed_f = 1'b1;
      default:                b_signed_f = 1'b0;
    endcase
  endfunction

  // Operand decode at accept: magnitudes, sign flags and divide special cases
  always_comb begin
    accept_s = start & ((state_q == S_IDLE) | (state_q == S_DONE));
    a_neg_s  = a_signed_f(op) & A[XLEN-1];
    b_neg_s  = b_signed_f(op) & B[XLEN-1];
    a_mag_s  = a_neg_s ? -A : A;
    b_mag_s  = b_neg_s ? -B : B;
    dz_s     = (B == {XLEN{1'b0}});
    ov_s     = op[2] & ~op[0] & (A == {1'b1, {(XLEN-1){1'b0}}}) & (B == {XLEN{1'b1}});
  end

  // One restoring-divide step, the product, and the signed result fix-up
  always_comb begin
    shifted_s   = {rem_q, quo_q[XLEN-1]};
    diff_s      = shifted_s - {1'b0, b_q};
    ge_s        = ~diff_s[XLEN];
    div_rem_n_s = ge_s ? diff_s[XLEN-1:0] : shifted_s[XLEN-1:0];
    div_quo_n_s = {quo_q[XLEN-2:0], ge_s};
    q_s         = neg_q ? -div_quo_n_s : div_quo_n_s;
    r_s         = a_neg_q ? -div_rem_n_s : div_rem_n_s;
    a_orig_s    = a_neg_q ? -a_q : a_q;
`ifdef MULDIV_ITER_MUL_EN
    mac_s       = {1'b0, rem_q} + ({(XLEN+1){quo_q[0]}} & {1'b0, a_q});
    mul_hi_n_s  = mac_s[XLEN:1];
    mul_lo_n_s  = {mac_s[0], quo_q[XLEN-1:1]};
    prod_mag_s  = {mul_hi_n_s, mul_lo_n_s};
`else
    prod_mag_s  = {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q};
`endif
    prod_s      = neg_q ? -prod_mag_s : prod_mag_s;
  end

  // Select the C / C_hi values that are written on entry to DONE
  always_comb begin
    res_lo_s = c_q;
    res_hi_s = c_hi_q;
    if (state_q == S_MUL) begin
      if (op_q[2]) begin
        // divide op issued with div_en=0
        res_lo_s = {XLEN{1'b0}};
        res_hi_s = {XLEN{1'b0}};
      end else if (op_q == 3'd0) begin
        res_lo_s = prod_s[XLEN-1:0];
        res_hi_s = prod_s[2*XLEN-1:XLEN];
      end else begin
        res_lo_s = prod_s[2*XLEN-1:XLEN];
        res_hi_s = prod_s[2*XLEN-1:XLEN];
      end
    end else if (dz_q) begin
      res_lo_s = op_q[1] ? a_orig_s : {XLEN{1'b1}};
      res_hi_s = a_orig_s;
    end else if (ov_q) begin
      res_lo_s = op_q[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
      res_hi_s = {XLEN{1'b0}};
    end else begin
      res_lo_s = op_q[1] ? r_s : q_s;
      res_hi_s = r_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          state_d = (op[2] & div_en) ? S_DIV : S_MUL;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL:   state_d = last_s ? S_DONE : S_MUL;
      S_DIV:   state_d = last_s ? S_DONE : S_DIV;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: stall request, valid pulse, final-iteration flag
  always_comb begin
    freeze_pipe = (state_q == S_MUL) | (state_q == S_DIV) | accept_s;
    valid       = (state_q == S_DONE);
`ifdef MULDIV_ITER_MUL_EN
    last_s      = (cnt_q == {CNT_W{1'b0}});
`else
    last_s      = (state_q == S_MUL) | (cnt_q == {CNT_W{1'b0}});
`endif
  end

  // Datapath register updates: operand capture, iteration, result write
  always_comb begin
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    a_neg_d = a_neg_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    c_d     = c_q;
    c_hi_d  = c_hi_q;
    if (accept_s) begin
      op_d    = op;
      a_d     = a_mag_s;
      b_d     = b_mag_s;
      a_neg_d = a_neg_s;
      neg_d   = a_neg_s ^ b_neg_s;
      dz_d    = dz_s;
      ov_d    = ov_s;
      rem_d   = {XLEN{1'b0}};
      if (op[2] & div_en) begin
        quo_d = a_mag_s;
        cnt_d = (dz_s | ov_s) ? {CNT_W{1'b0}} : CNT_W'(XLEN-1);
      end else begin
        quo_d = b_mag_s;
        cnt_d = CNT_W'(XLEN-1);
      end
    end else if ((state_q == S_MUL) || (state_q == S_DIV)) begin
      if (state_q == S_DIV) begin
        rem_d = div_rem_n_s;
        quo_d = div_quo_n_s;
      end else begin
`ifdef MULDIV_ITER_MUL_EN
        rem_d = mul_hi_n_s;
        quo_d = mul_lo_n_s;
`else
        rem_d = rem_q;
        quo_d = quo_q;
`endif
      end
      if (last_s) begin
        c_d    = res_lo_s;
        c_hi_d = res_hi_s;
      end else begin
        cnt_d  = cnt_q - CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= {CNT_W{1'b0}};
      op_q    <= 3'd0;
      a_q     <= {XLEN{1'b0}};
      b_q     <= {XLEN{1'b0}};
      rem_q   <= {XLEN{1'b0}};
      quo_q   <= {XLEN{1'b0}};
      a_neg_q <= 1'b0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      c_q     <= {XLEN{1'b0}};
      c_hi_q  <= {XLEN{1'b0}};
    end else begin
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      a_neg_q <= a_neg_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      c_q     <= c_d;
      c_hi_q  <= c_hi_d;
    end
  end

  assign C    = c_q;
  assign C_hi = c_hi_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Directed testbench for riscv_muldiv_unit (default XLEN=32).
module tb_riscv_muldiv_unit;

`ifdef MULDIV_ITER_MUL_EN
  localparam int MUL_LAT = 33;
`else
  localparam int MUL_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        div_en;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        freeze_pipe, valid;
  logic [31:0] C, C_hi;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .div_en(div_en), .op(op),
    .A(A), .B(B), .freeze_pipe(freeze_pipe), .valid(valid), .C(C), .C_hi(C_hi)
  );

  always #5 clk = ~clk;

  // Issue one op and wait (bounded) for valid; returns results, latency, freeze samples
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic de, output logic [31:0] c, output logic [31:0] chi,
                       output int lat, output logic fz0, output logic fz1);
    logic got;
    @(posedge clk); #1;
    start = 1'b1; op = o; A = a; B = b; div_en = de;
    @(negedge clk);
    fz0 = freeze_pipe;
    lat = 0; got = 1'b0; fz1 = 1'b0; c = 32'd0; chi = 32'd0;
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      @(negedge clk);
      if (lat == 1) fz1 = freeze_pipe;
      if (valid) begin
        got = 1'b1; c = C; chi = C_hi;
      end
    end
    if (!got) lat = 999;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; div_en = 1'b1; op = 3'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (C !== 32'd0) begin n_fail++; $display("FAIL reset_C: got %h expected %h", C, 32'd0); end
    n_checks++; if (C_hi !== 32'd0) begin n_fail++; $display("FAIL reset_C_hi: got %h expected %h", C_hi, 32'd0); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_checks++; if (freeze_pipe !== 1'b0) begin n_fail++; $display("FAIL reset_freeze: got %b expected 0", freeze_pipe); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [31:0] c, chi; int lat; logic fz0, fz1;
    do_op(3'd0, 32'd7, 32'hFFFFFFFD, 1'b1, c, chi, lat, fz0, fz1);
    n_checks++; if (c !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_C: got %h expected %h", c, 32'hFFFFFFEB); end
    n_checks++; if (chi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mul_C_hi: got %h expected %h", chi, 32'hFFFFFFFF); end
    n_checks++; if (lat != MUL_LAT) begin n_fail++; $display("FAIL mul_latency: got %0d expected %0d", lat, MUL_LAT); end
    n_checks++; if (fz0 !== 1'b1) begin n_fail++; $display("FAIL mul_freeze_c0: got %b expected 1", fz0); end
    n_checks++; if (fz1 !== 1'b1) begin n_fail++; $display("FAIL mul_freeze_c1: got %b expected 1", fz1); end
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, c, chi, lat, fz0, fz1);
    n_checks++; if (c !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mulhu_C: got %h expected %h", c, 32'hFFFFFFFE); end
    n_checks++; if (chi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mulhu_C_hi: got %h expected %h", chi, 32'hFFFFFFFE); end
    do_op(3'd2, 32'hFFFFFFFF, 32'd2, 1'b1, c, chi, lat, fz0, fz1);
    n_checks++; if (c !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulhsu_C: got %h expected %h", c, 32'hFFFFFFFF); end
    do_op(3'd1, 32'h80000000, 32'h80000000, 1'b1, c, chi, lat, fz0, fz1);
    n_checks++; if (c !== 32'h40000000) begin n_fail++; $display("FAIL mulh_C: got %h expected %h", c, 32'h40000000); end
    do_op(3'd1, 32'hFFFFFFFF, 32'd3, 1'b1, c, chi, lat, fz0, fz1);
    n_checks++; if (c !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulh_neg_C: got %h expected %h", c, 32'hFFFFFFFF); end
  endtask

  task automatic test_div();
    logic [31:0] c, chi; int lat; logic fz0, fz1;
    do_op(3'd4, 32'hFFFFFFEC, 32'd3, 1'b1, c, chi, lat, fz0, fz1);
    n_checks++; if (c !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL div_C: got %h expected %h", c, 32'hFFFFFFFA); end
    n_checks++; if (chi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL div_C_hi: got %h expected %h", chi, 32'hFFFFFFFE); end
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL div_latency: got %0d expected 33", lat); end
    do_op(3'd7, 32'd20, 32'd3, 1'b1, c, chi, lat, fz0, fz1);
    n_checks++; if (c !== 32'd2) begin n_fail++; $display("FAIL remu_C: got %h expected %h", c, 32'd2); end
    do_op(3'd5, 32'd100, 32'd7, 1'b1, c, chi, lat, fz0, fz1);
    n_checks++; if (c !== 32'd14) begin n_fail++; $display("FAIL divu_C: got %h expected %h", c, 32'd14); end
    n_checks++; if (chi !== 32'd2) begin n_fail++; $display("FAIL divu_C_hi: got %h expected %h", chi, 32'd2); end
    do_op(3'd6, 32'hFFFFFFEC, 32'd3, 1'b1, c, chi, lat, fz0, fz1);
    n_checks++; if (c !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL rem_C: got %h expected %h", c, 32'hFFFFFFFE); end
    do_op(3'd5, 32'hFFFFFFFF, 32'h00010000, 1'b1, c, chi, lat, fz0, fz1);
    n_checks++; if (c !== 32'h0000FFFF) begin n_fail++; $display("FAIL divu_big_C: got %h expected %h", c, 32'h0000FFFF); end
  endtask

  task automatic test_div_special();
    logic [31:0] c, chi; int lat; logic fz0, fz1;
    do_op(3'd5, 32'd5, 32'd0, 1'b1, c, chi, lat, fz0, fz1);
    n_checks++; if (c !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu0_C: got %h expected %h", c, 32'hFFFFFFFF); end
    n_checks++; if (chi !== 32'd5) begin n_fail++; $display("FAIL divu0_C_hi: got %h expected %h", chi, 32'd5); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL divu0_latency: got %0d expected 2", lat); end
    do_op(3'd4, 32'hFFFFFFFB, 32'd0, 1'b1, c, chi, lat, fz0, fz1);
    n_checks++; if (c !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div0_C: got %h expected %h", c, 32'hFFFFFFFF); end
    n_checks++; if (chi !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL div0_C_hi: got %h expected %h", chi, 32'hFFFFFFFB); end
    do_op(3'd6, 32'hFFFFFFFB, 32'd0, 1'b1, c, chi, lat, fz0, fz1);
    n_checks++; if (c !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL rem0_C: got %h expected %h", c, 32'hFFFFFFFB); end
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 1'b1, c, chi, lat, fz0, fz1);
    n_checks++; if (c !== 32'h80000000) begin n_fail++; $display("FAIL ovf_C: got %h expected %h", c, 32'h80000000); end
    n_checks++; if (chi !== 32'd0) begin n_fail++; $display("FAIL ovf_C_hi: got %h expected %h", chi, 32'd0); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL ovf_latency: got %0d expected 2", lat); end
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 1'b1, c, chi, lat, fz0, fz1);
    n_checks++; if (c !== 32'd0) begin n_fail++; $display("FAIL ovf_rem_C: got %h expected %h", c, 32'd0); end
  endtask

  task automatic test_div_disabled();
    logic [31:0] c, chi; int lat; logic fz0, fz1;
    do_op(3'd4, 32'd20, 32'd3, 1'b0, c, chi, lat, fz0, fz1);
    n_checks++; if (c !== 32'd0) begin n_fail++; $display("FAIL dis_C: got %h expected %h", c, 32'd0); end
    n_checks++; if (chi !== 32'd0) begin n_fail++; $display("FAIL dis_C_hi: got %h expected %h", chi, 32'd0); end
    n_checks++; if (lat != MUL_LAT) begin n_fail++; $display("FAIL dis_latency: got %0d expected %0d", lat, MUL_LAT); end
    div_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int lat; logic got;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd5; A = 32'd100; B = 32'd7; div_en = 1'b1;
    lat = 0; got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 5 || lat == 10) begin
        start = 1'b1; op = 3'd0; A = 32'd1; B = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (lat == 10) begin
        n_checks++; if (freeze_pipe !== 1'b1) begin n_fail++; $display("FAIL b2b_freeze_div: got %b expected 1", freeze_pipe); end
      end
      if (valid) got = 1'b1;
    end
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL b2b_div_latency: got %0d expected 33", lat); end
    n_checks++; if (C !== 32'd14) begin n_fail++; $display("FAIL b2b_div_C: got %h expected %h", C, 32'd14); end
    n_checks++; if (C_hi !== 32'd2) begin n_fail++; $display("FAIL b2b_div_C_hi: got %h expected %h", C_hi, 32'd2); end
    // issue the next op while still in DONE
    start = 1'b1; op = 3'd5; A = 32'd9; B = 32'd0;
    #1;
    n_checks++; if (freeze_pipe !== 1'b1) begin n_fail++; $display("FAIL b2b_freeze_accept: got %b expected 1", freeze_pipe); end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_c1: got %b expected 0", valid); end
    @(negedge clk);
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_c2: got %b expected 1", valid); end
    n_checks++; if (C !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL b2b_second_C: got %h expected %h", C, 32'hFFFFFFFF); end
    n_checks++; if (C_hi !== 32'd9) begin n_fail++; $display("FAIL b2b_second_C_hi: got %h expected %h", C_hi, 32'd9); end
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_pulse: got %b expected 0", valid); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] c, chi; int lat; logic fz0, fz1; int seen;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd4; A = 32'hFFFFFFEC; B = 32'd3; div_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++; if (C !== 32'd0) begin n_fail++; $display("FAIL rstmid_C: got %h expected %h", C, 32'd0); end
    n_checks++; if (C_hi !== 32'd0) begin n_fail++; $display("FAIL rstmid_C_hi: got %h expected %h", C_hi, 32'd0); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", valid); end
    n_checks++; if (freeze_pipe !== 1'b0) begin n_fail++; $display("FAIL rstmid_freeze: got %b expected 0", freeze_pipe); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid === 1'b1 || freeze_pipe === 1'b1) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_aborted: got %0d active cycles expected 0", seen); end
    do_op(3'd4, 32'hFFFFFFEC, 32'd3, 1'b1, c, chi, lat, fz0, fz1);
    n_checks++; if (c !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL rstmid_after_C: got %h expected %h", c, 32'hFFFFFFFA); end
    n_checks++; if (chi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL rstmid_after_C_hi: got %h expected %h", chi, 32'hFFFFFFFE); end
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL rstmid_after_latency: got %0d expected 33", lat); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_div_disabled();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
